// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-subset core: opcodes, R-type function
// codes, ALU operation codes and run-mode select values.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operations, encoded as shown on the o_alu_ctrl debug port
    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SLL = 4'd3,
        ALU_SRL = 4'd4,
        ALU_LUI = 4'd5,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_op_t;

    // Run-mode select {clk_ctrl1, clk_ctrl0}
    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_STEP = 2'b01,
        MODE_SLOW = 2'b10,
        MODE_RUN  = 2'b11
    } run_mode_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU. Shifts and LUI operate on operand b; comp reports
// equality and signed less-than of a and b for branches and debug.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  logic [3:0]  ctrl,
    output logic [31:0] y,
    output logic [1:0]  comp
);

    logic lt;

    assign lt   = $signed(a) < $signed(b);
    assign comp = {lt, a == b};

    // Operation select
    always_comb begin
        // NOTE: default first so every path assigns y and no latch is inferred.
        y = '0;
        case (ctrl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {31'b0, lt};
            ALU_NOR: y = ~(a | b);
            ALU_SLL: y = b << shamt;
            ALU_SRL: y = b >> shamt;
            ALU_LUI: y = {b[15:0], 16'b0};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-subset core with unified 8K x 32 RAM, a run-mode
// clock-enable controller and combinational debug views of the current
// instruction. A host write port has priority over the CPU and stalls it.
module mips_cpu
    import mips_pkg::*;
#(
    parameter int DIV_LOG2 = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ctrl0,
    input  logic        clk_ctrl1,
    input  logic        clk_ctrl_clk,
    output logic        o_clock,
    output logic [11:0] o_pc,
    output logic [31:0] o_alu_y,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [3:0]  o_alu_ctrl,
    output logic [1:0]  o_alu_comp,
    output logic [31:0] o_reg_data1,
    output logic [31:0] o_reg_data2,
    output logic [4:0]  o_reg_idx1,
    output logic [4:0]  o_reg_idx2,
    output logic [31:0] o_reg_wdata,
    output logic [4:0]  o_reg_widx,
    output logic        o_reg_wen,
    output logic [12:0] o_ram_addr,
    output logic [31:0] o_ram_rdata,
    output logic [31:0] o_ram_wdata,
    output logic        o_ram_wen,
    input  logic [12:0] i_ram_addr,
    input  logic [31:0] i_ram_wdata,
    input  logic        i_ram_wen
);

    logic [DIV_LOG2-1:0] div_cnt;
    logic                div_tick;
    logic                sync1, sync2, sync3, step_edge;
    logic                mode_en, step;

    logic [11:0] pc, pc_plus1, next_pc;
    logic [31:0] ram [0:8191];
    logic [31:0] regs [0:31];
    logic [31:0] instr, rs_data, rt_data, imm_ext, alu_b, alu_y, ram_rdata;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [1:0]  alu_comp;

    alu_op_t alu_ctrl;
    logic    use_imm, imm_zext, reg_write, mem_write, mem_read, dst_rd;
    logic    is_beq, is_bne, is_jump, is_jal, is_jr;

    // ---------------- clock-enable controller ----------------
    assign div_tick  = &div_cnt;
    assign step_edge = sync2 & ~sync3;

    // Free-running divider and manual-step synchroniser with edge detect
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            div_cnt <= '0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            sync1   <= clk_ctrl_clk;
            sync2   <= sync1;
            sync3   <= sync2;
        end
    end

    // Run-mode enable select
    always_comb begin
        mode_en = 1'b0;
        case (run_mode_t'({clk_ctrl1, clk_ctrl0}))
            MODE_RUN:  mode_en = 1'b1;
            MODE_SLOW: mode_en = div_tick;
            MODE_STEP: mode_en = step_edge;
            default:   mode_en = 1'b0;
        endcase
    end

    assign step    = mode_en & ~i_ram_wen & ~reset;
    assign o_clock = step;

    // ---------------- fetch and decode ----------------
    assign instr    = ram[{1'b0, pc}];
    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign pc_plus1 = pc + 12'd1;

    // Instruction decoder; unlisted opcodes/functs fall through as NOPs
    always_comb begin
        alu_ctrl  = ALU_ADD;
        use_imm   = 1'b0;
        imm_zext  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        dst_rd    = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_jump   = 1'b0;
        is_jal    = 1'b0;
        is_jr     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dst_rd = 1'b1;
                case (funct)
                    FN_ADD: begin alu_ctrl = ALU_ADD; reg_write = 1'b1; end
                    FN_SUB: begin alu_ctrl = ALU_SUB; reg_write = 1'b1; end
                    FN_AND: begin alu_ctrl = ALU_AND; reg_write = 1'b1; end
                    FN_OR:  begin alu_ctrl = ALU_OR;  reg_write = 1'b1; end
                    FN_NOR: begin alu_ctrl = ALU_NOR; reg_write = 1'b1; end
                    FN_SLT: begin alu_ctrl = ALU_SLT; reg_write = 1'b1; end
                    FN_SLL: begin alu_ctrl = ALU_SLL; reg_write = 1'b1; end
                    FN_SRL: begin alu_ctrl = ALU_SRL; reg_write = 1'b1; end
                    FN_JR:  is_jr = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI: begin use_imm = 1'b1; reg_write = 1'b1; end
            OP_SLTI: begin alu_ctrl = ALU_SLT; use_imm = 1'b1; reg_write = 1'b1; end
            OP_ANDI: begin alu_ctrl = ALU_AND; use_imm = 1'b1; imm_zext = 1'b1; reg_write = 1'b1; end
            OP_ORI:  begin alu_ctrl = ALU_OR;  use_imm = 1'b1; imm_zext = 1'b1; reg_write = 1'b1; end
            OP_LUI:  begin alu_ctrl = ALU_LUI; use_imm = 1'b1; imm_zext = 1'b1; reg_write = 1'b1; end
            OP_LW:   begin use_imm = 1'b1; mem_read = 1'b1; reg_write = 1'b1; end
            OP_SW:   begin use_imm = 1'b1; mem_write = 1'b1; end
            OP_BEQ:  begin alu_ctrl = ALU_SUB; is_beq = 1'b1; end
            OP_BNE:  begin alu_ctrl = ALU_SUB; is_bne = 1'b1; end
            OP_J:    is_jump = 1'b1;
            OP_JAL:  begin is_jal = 1'b1; reg_write = 1'b1; end
            default: ;
        endcase
    end

    // ---------------- register file and execute ----------------
    assign rs_data = (rs == 5'd0) ? '0 : regs[rs];
    assign rt_data = (rt == 5'd0) ? '0 : regs[rt];
    assign imm_ext = imm_zext ? {16'b0, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = use_imm ? imm_ext : rt_data;

    mips_alu u_alu (
        .a     (rs_data),
        .b     (alu_b),
        .shamt (shamt),
        .ctrl  (alu_ctrl),
        .y     (alu_y),
        .comp  (alu_comp)
    );

    assign ram_rdata   = ram[alu_y[14:2]];
    assign o_reg_wdata = is_jal ? {18'b0, pc_plus1, 2'b00} : (mem_read ? ram_rdata : alu_y);
    assign o_reg_widx  = is_jal ? 5'd31 : (dst_rd ? rd : rt);
    assign o_reg_wen   = reg_write & step;
    assign o_ram_wen   = mem_write & step;

    // Register file write port; $0 is never written so it always reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (o_reg_wen && o_reg_widx != 5'd0) begin
            regs[o_reg_widx] <= o_reg_wdata;
        end
    end

    // Single RAM write port: host load wins over CPU store
    always_ff @(posedge clk) begin
        // NOTE: RAM contents have no reset so the array maps onto block memory.
        if (i_ram_wen)
            ram[i_ram_addr] <= i_ram_wdata;
        else if (o_ram_wen)
            ram[alu_y[14:2]] <= rt_data;
    end

    // Next-PC select (12-bit word index, wraps naturally)
    always_comb begin
        next_pc = pc_plus1;
        if (is_jump || is_jal)
            next_pc = instr[11:0];
        else if (is_jr)
            next_pc = rs_data[13:2];
        else if ((is_beq && alu_comp[0]) || (is_bne && !alu_comp[0]))
            next_pc = pc_plus1 + imm[11:0];
    end

    // Program counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pc <= '0;
        else if (step) pc <= next_pc;
    end

    // ---------------- debug views ----------------
    assign o_pc        = pc;
    assign o_alu_y     = alu_y;
    assign o_alu_a     = rs_data;
    assign o_alu_b     = alu_b;
    assign o_alu_ctrl  = alu_ctrl;
    assign o_alu_comp  = alu_comp;
    assign o_reg_data1 = rs_data;
    assign o_reg_data2 = rt_data;
    assign o_reg_idx1  = rs;
    assign o_reg_idx2  = rt;
    assign o_ram_addr  = alu_y[14:2];
    assign o_ram_rdata = ram_rdata;
    assign o_ram_wdata = rt_data;

endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: a program trace table checked instruction by
// instruction, then hand sequences for PC wrap, host-load stall, halt,
// manual step and slow modes.
module tb_mips_cpu;

    logic        clk, reset, clk_ctrl0, clk_ctrl1, clk_ctrl_clk;
    logic        o_clock, o_reg_wen, o_ram_wen, i_ram_wen;
    logic [11:0] o_pc;
    logic [31:0] o_alu_y, o_alu_a, o_alu_b, o_reg_data1, o_reg_data2, o_reg_wdata;
    logic [31:0] o_ram_rdata, o_ram_wdata, i_ram_wdata;
    logic [3:0]  o_alu_ctrl;
    logic [1:0]  o_alu_comp;
    logic [4:0]  o_reg_idx1, o_reg_idx2, o_reg_widx;
    logic [12:0] o_ram_addr, i_ram_addr;

    int n_vec = 0;
    int n_err = 0;

    mips_cpu #(.DIV_LOG2(3)) dut (
        .clk(clk), .reset(reset), .clk_ctrl0(clk_ctrl0), .clk_ctrl1(clk_ctrl1),
        .clk_ctrl_clk(clk_ctrl_clk), .o_clock(o_clock), .o_pc(o_pc),
        .o_alu_y(o_alu_y), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .o_alu_ctrl(o_alu_ctrl), .o_alu_comp(o_alu_comp),
        .o_reg_data1(o_reg_data1), .o_reg_data2(o_reg_data2),
        .o_reg_idx1(o_reg_idx1), .o_reg_idx2(o_reg_idx2),
        .o_reg_wdata(o_reg_wdata), .o_reg_widx(o_reg_widx), .o_reg_wen(o_reg_wen),
        .o_ram_addr(o_ram_addr), .o_ram_rdata(o_ram_rdata), .o_ram_wdata(o_ram_wdata),
        .o_ram_wen(o_ram_wen), .i_ram_addr(i_ram_addr), .i_ram_wdata(i_ram_wdata),
        .i_ram_wen(i_ram_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [11:0] pc;
        logic        chk_y;
        logic [31:0] y;
        logic        chk_comp;
        logic [1:0]  comp;
        logic        rwen;
        logic [4:0]  widx;
        logic [31:0] wdata;
        logic        mwen;
    } vec_t;

    vec_t vecs [23];

    initial begin
        int cnt;

        //              instr          pc      chk_y y             chk_c comp   rwen  widx   wdata          mwen
        vecs[0]  = '{32'h20010005, 12'd0,  1'b1, 32'h00000005, 1'b1, 2'b10, 1'b1, 5'd1,  32'h00000005, 1'b0}; // addi $1,$0,5
        vecs[1]  = '{32'h2002FFFD, 12'd1,  1'b1, 32'hFFFFFFFD, 1'b1, 2'b00, 1'b1, 5'd2,  32'hFFFFFFFD, 1'b0}; // addi $2,$0,-3
        vecs[2]  = '{32'h00221820, 12'd2,  1'b1, 32'h00000002, 1'b1, 2'b00, 1'b1, 5'd3,  32'h00000002, 1'b0}; // add $3,$1,$2
        vecs[3]  = '{32'h0041202A, 12'd3,  1'b1, 32'h00000001, 1'b1, 2'b10, 1'b1, 5'd4,  32'h00000001, 1'b0}; // slt $4,$2,$1
        vecs[4]  = '{32'hAC030008, 12'd4,  1'b1, 32'h00000008, 1'b1, 2'b10, 1'b0, 5'd0,  32'h0,        1'b1}; // sw $3,8($0)
        vecs[5]  = '{32'h8C050008, 12'd5,  1'b1, 32'h00000008, 1'b1, 2'b10, 1'b1, 5'd5,  32'h00000002, 1'b0}; // lw $5,8($0)
        vecs[6]  = '{32'h10210002, 12'd6,  1'b1, 32'h00000000, 1'b1, 2'b01, 1'b0, 5'd0,  32'h0,        1'b0}; // beq $1,$1,+2
        vecs[7]  = '{32'h14210005, 12'd9,  1'b1, 32'h00000000, 1'b1, 2'b01, 1'b0, 5'd0,  32'h0,        1'b0}; // bne $1,$1,+5
        vecs[8]  = '{32'h0C000010, 12'd10, 1'b0, 32'h0,        1'b0, 2'b00, 1'b1, 5'd31, 32'h0000002C, 1'b0}; // jal 0x010
        vecs[9]  = '{32'h20000007, 12'd16, 1'b1, 32'h00000007, 1'b1, 2'b10, 1'b1, 5'd0,  32'h00000007, 1'b0}; // addi $0,$0,7
        vecs[10] = '{32'h001F3820, 12'd17, 1'b1, 32'h0000002C, 1'b1, 2'b10, 1'b1, 5'd7,  32'h0000002C, 1'b0}; // add $7,$0,$31
        vecs[11] = '{32'h03E00008, 12'd18, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 5'd0,  32'h0,        1'b0}; // jr $31
        vecs[12] = '{32'h3C081234, 12'd11, 1'b1, 32'h12340000, 1'b1, 2'b10, 1'b1, 5'd8,  32'h12340000, 1'b0}; // lui $8,0x1234
        vecs[13] = '{32'h35098001, 12'd12, 1'b1, 32'h12348001, 1'b1, 2'b00, 1'b1, 5'd9,  32'h12348001, 1'b0}; // ori $9,$8,0x8001
        vecs[14] = '{32'h304AFFFF, 12'd13, 1'b1, 32'h0000FFFD, 1'b1, 2'b10, 1'b1, 5'd10, 32'h0000FFFD, 1'b0}; // andi $10,$2,0xffff
        vecs[15] = '{32'h000158C0, 12'd14, 1'b1, 32'h00000028, 1'b0, 2'b00, 1'b1, 5'd11, 32'h00000028, 1'b0}; // sll $11,$1,3
        vecs[16] = '{32'h08000014, 12'd15, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 5'd0,  32'h0,        1'b0}; // j 0x014
        vecs[17] = '{32'h00086402, 12'd20, 1'b1, 32'h00001234, 1'b0, 2'b00, 1'b1, 5'd12, 32'h00001234, 1'b0}; // srl $12,$8,16
        vecs[18] = '{32'h00006827, 12'd21, 1'b1, 32'hFFFFFFFF, 1'b1, 2'b01, 1'b1, 5'd13, 32'hFFFFFFFF, 1'b0}; // nor $13,$0,$0
        vecs[19] = '{32'h00227022, 12'd22, 1'b1, 32'h00000008, 1'b1, 2'b00, 1'b1, 5'd14, 32'h00000008, 1'b0}; // sub $14,$1,$2
        vecs[20] = '{32'h284F0000, 12'd23, 1'b1, 32'h00000001, 1'b1, 2'b10, 1'b1, 5'd15, 32'h00000001, 1'b0}; // slti $15,$2,0
        vecs[21] = '{32'hFC210005, 12'd24, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 5'd0,  32'h0,        1'b0}; // undefined -> NOP
        vecs[22] = '{32'h08000019, 12'd25, 1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 5'd0,  32'h0,        1'b0}; // j 0x019 (self loop)

        reset = 1'b1; clk_ctrl0 = 1'b1; clk_ctrl1 = 1'b1; clk_ctrl_clk = 1'b0;
        i_ram_wen = 1'b0; i_ram_addr = '0; i_ram_wdata = '0;

        // Load the program while held in reset
        @(negedge clk); #1;
        foreach (vecs[i]) begin
            i_ram_addr = {1'b0, vecs[i].pc}; i_ram_wdata = vecs[i].instr; i_ram_wen = 1'b1;
            @(negedge clk); #1;
        end
        i_ram_wen = 1'b0; #1;

        check("reset.pc", {20'b0, o_pc}, 32'd0);
        check("reset.clock", {31'b0, o_clock}, 32'd0);
        check("reset.reg_wen", {31'b0, o_reg_wen}, 32'd0);
        check("reset.ram_wen", {31'b0, o_ram_wen}, 32'd0);

        @(negedge clk); reset = 1'b0; #1;

        // Program trace: each row is the instruction current at this cycle
        foreach (vecs[i]) begin
            check($sformatf("pc%0d.pc", vecs[i].pc), {20'b0, o_pc}, {20'b0, vecs[i].pc});
            check($sformatf("pc%0d.clock", vecs[i].pc), {31'b0, o_clock}, 32'd1);
            check($sformatf("pc%0d.reg_wen", vecs[i].pc), {31'b0, o_reg_wen}, {31'b0, vecs[i].rwen});
            check($sformatf("pc%0d.ram_wen", vecs[i].pc), {31'b0, o_ram_wen}, {31'b0, vecs[i].mwen});
            if (vecs[i].chk_y)
                check($sformatf("pc%0d.alu_y", vecs[i].pc), o_alu_y, vecs[i].y);
            if (vecs[i].chk_comp)
                check($sformatf("pc%0d.alu_comp", vecs[i].pc), {30'b0, o_alu_comp}, {30'b0, vecs[i].comp});
            if (vecs[i].rwen) begin
                check($sformatf("pc%0d.widx", vecs[i].pc), {27'b0, o_reg_widx}, {27'b0, vecs[i].widx});
                check($sformatf("pc%0d.wdata", vecs[i].pc), o_reg_wdata, vecs[i].wdata);
            end
            case (vecs[i].pc)
                12'd3: begin
                    check("slt.alu_a", o_alu_a, 32'hFFFFFFFD);
                    check("slt.alu_b", o_alu_b, 32'h00000005);
                    check("slt.alu_ctrl", {28'b0, o_alu_ctrl}, 32'd7);
                    check("slt.idx1", {27'b0, o_reg_idx1}, 32'd2);
                    check("slt.idx2", {27'b0, o_reg_idx2}, 32'd1);
                end
                12'd4: begin
                    check("sw.ram_addr", {19'b0, o_ram_addr}, 32'd2);
                    check("sw.ram_wdata", o_ram_wdata, 32'd2);
                end
                12'd5: begin
                    check("lw.ram_addr", {19'b0, o_ram_addr}, 32'd2);
                    check("lw.ram_rdata", o_ram_rdata, 32'd2);
                end
                12'd17: begin
                    check("zero_reg.data1", o_reg_data1, 32'd0);
                    check("ra.data2", o_reg_data2, 32'h0000002C);
                end
                12'd18: check("jr.data1", o_reg_data1, 32'h0000002C);
                default: ;
            endcase
            @(negedge clk); #1;
        end
        check("loop.pc", {20'b0, o_pc}, 32'd25);

        // Wrap: jump to 4095, whose successor is word 0
        i_ram_wen = 1'b1; i_ram_addr = 13'd4095; i_ram_wdata = 32'h20100009; // addi $16,$0,9
        @(negedge clk); #1;
        i_ram_addr = 13'd25; i_ram_wdata = 32'h08000FFF;                     // j 0xFFF
        @(negedge clk); #1;
        i_ram_wen = 1'b0;
        @(negedge clk); #1;
        check("wrap.pc_top", {20'b0, o_pc}, 32'd4095);
        check("wrap.wdata", o_reg_wdata, 32'd9);
        @(negedge clk); #1;
        check("wrap.pc_zero", {20'b0, o_pc}, 32'd0);

        // Host load in run mode: CPU must not advance while i_ram_wen is high
        for (int k = 0; k < 3; k++) begin
            i_ram_wen = 1'b1; i_ram_addr = 13'd100 + 13'(k);
            i_ram_wdata = (k == 0) ? 32'hDEADBEEF : (k == 1) ? 32'h12345678 : 32'hA5A5A5A5;
            #1;
            check($sformatf("host%0d.clock", k), {31'b0, o_clock}, 32'd0);
            @(negedge clk); #1;
            check($sformatf("host%0d.pc", k), {20'b0, o_pc}, 32'd0);
        end
        i_ram_wen = 1'b0;
        check("host.ram100", dut.ram[100], 32'hDEADBEEF);
        check("host.ram101", dut.ram[101], 32'h12345678);
        check("host.ram102", dut.ram[102], 32'hA5A5A5A5);

        // Halt: PC static
        clk_ctrl1 = 1'b0; clk_ctrl0 = 1'b0; #1;
        check("halt.clock", {31'b0, o_clock}, 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("halt.pc", {20'b0, o_pc}, 32'd0);

        // Manual step: three pulses retire exactly three instructions
        clk_ctrl0 = 1'b1; cnt = 0;
        for (int c = 0; c < 36; c++) begin
            clk_ctrl_clk = (c < 30) && ((c % 10) < 4);
            if (o_clock) cnt++;
            @(negedge clk); #1;
        end
        check("step.retires", cnt, 32'd3);
        check("step.pc", {20'b0, o_pc}, 32'd3);

        // Slow mode with DIV_LOG2=3: one retire every 8 clk
        clk_ctrl1 = 1'b1; clk_ctrl0 = 1'b0; cnt = 0; #1;
        for (int c = 0; c < 32; c++) begin
            if (o_clock) cnt++;
            @(negedge clk); #1;
        end
        check("slow.retires", cnt, 32'd4);
        check("slow.pc", {20'b0, o_pc}, 32'd9);

        clk_ctrl1 = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
